// File: rtl/core4_oci_pkg.sv
// Shared constants and capture-sequencer states for the Core4 OCI trace path.
package core4_oci_pkg;

    localparam int NUM_CORES  = 4;
    localparam int BUF_W      = 30;
    localparam int CNT_W      = 4;
    localparam int ID_W       = $clog2(NUM_CORES);
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } oci_state_e;

endpackage

// File: rtl/core4_oci_trace_fifo.sv
// Show-ahead FIFO with occupancy output; head is visible while level is non-zero.
// Latency: a push in cycle N is at the head in N+1 when the FIFO was empty.
// Backpressure: pushes when full and pops when empty are ignored; the caller gates on level.
module core4_oci_trace_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign push_en   = push && (level != LW'(DEPTH));
    assign pop_en    = pop && (level != '0);
    assign out_valid = (level != '0);
    // Empty FIFO presents zero rather than a stale entry.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_en) - LW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/core4_oci_trace_arbiter.sv
// Round-robin merge of per-core OCI trace frames into one tagged trace FIFO, with capture sequencing.
// Latency: frame granted in cycle N is at the FIFO head in N+1 when empty; one grant per cycle.
// Backpressure: no grant while the FIFO is full (a same-cycle pop does not help); stalls are logged.
module core4_oci_trace_arbiter #(
    parameter  int NUM_CORES  = core4_oci_pkg::NUM_CORES,
    parameter  int BUF_W      = core4_oci_pkg::BUF_W,
    parameter  int CNT_W      = core4_oci_pkg::CNT_W,
    parameter  int FIFO_DEPTH = core4_oci_pkg::FIFO_DEPTH,
    localparam int ID_W       = $clog2(NUM_CORES),
    localparam int DAT_W      = ID_W + CNT_W + BUF_W,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       test_ending,
    input  logic [NUM_CORES-1:0]       req_valid,
    input  logic [NUM_CORES*BUF_W-1:0] req_buffer,
    input  logic [NUM_CORES*CNT_W-1:0] req_count,
    output logic [NUM_CORES-1:0]       req_ready,
    output logic                       out_valid,
    output logic [DAT_W-1:0]           out_data,
    input  logic                       out_ready,
    output logic [LVL_W-1:0]           fifo_level,
    output logic [NUM_CORES-1:0]       stall_seen,
    input  logic                       clear_stall,
    output logic                       test_has_ended
);

    import core4_oci_pkg::*;

    oci_state_e      state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            grant_en;
    logic            fifo_full;
    logic            push;
    logic [DAT_W-1:0] push_dat;

    assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign grant_en  = (state == RUN) && !fifo_full;
    assign push      = grant_en && grant_found;

    // Search starts one past the last winner so every core gets a turn.
    always_comb begin : arb_search
        int              cand;
        logic [ID_W-1:0] cand_id;
        grant_idx   = last_grant;
        grant_found = 1'b0;
        cand        = 0;
        cand_id     = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (push) req_ready[grant_idx] = 1'b1;
    end

    assign push_dat = {grant_idx,
                       req_count[grant_idx*CNT_W +: CNT_W],
                       req_buffer[grant_idx*BUF_W +: BUF_W]};

    core4_oci_trace_fifo #(
        .WIDTH (DAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_dat),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_CORES - 1);
            stall_seen     <= '0;
            test_has_ended <= 1'b0;
        end else begin
            if (push) last_grant <= grant_idx;

            if (clear_stall)
                stall_seen <= '0;
            else if (state == RUN && fifo_full)
                stall_seen <= stall_seen | req_valid;

            test_has_ended <= (state == DONE);

            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN: begin
                    if (test_ending)  state <= DRAIN;
                    else if (!enable) state <= IDLE;
                end
                DRAIN:   if (fifo_level == '0) state <= DONE;
                DONE:    if (!enable) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core4_oci_trace_arbiter.sv
// Directed bench for the Core4 OCI trace arbiter: vector table plus multi-cycle sequences.
module tb_core4_oci_trace_arbiter;

    localparam int NC = 4;
    localparam int BW = 30;
    localparam int CW = 4;
    localparam int DW = 36;
    localparam int LW = 5;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             test_ending;
    logic [NC-1:0]    req_valid;
    logic [NC*BW-1:0] req_buffer;
    logic [NC*CW-1:0] req_count;
    logic [NC-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic [LW-1:0]    fifo_level;
    logic [NC-1:0]    stall_seen;
    logic             clear_stall;
    logic             test_has_ended;

    logic [BW-1:0] bq [NC];
    logic [CW-1:0] cq [NC];

    int errors = 0;
    int checks = 0;
    int accepted;

    core4_oci_trace_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .test_ending    (test_ending),
        .req_valid      (req_valid),
        .req_buffer     (req_buffer),
        .req_count      (req_count),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .stall_seen     (stall_seen),
        .clear_stall    (clear_stall),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_buffer = '0;
        req_count  = '0;
        for (int i = 0; i < NC; i++) begin
            req_buffer[i*BW +: BW] = bq[i];
            req_count[i*CW +: CW]  = cq[i];
        end
    end

    typedef struct {
        logic          en;
        logic [NC-1:0] vld;
        logic          ordy;
        logic [NC-1:0] erdy;
        logic          eovld;
        int            ehead;
        int            elvl;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic en, input logic [NC-1:0] vld, input logic ordy,
                                input logic [NC-1:0] erdy, input logic eovld,
                                input int ehead, input int elvl);
        vec_t v;
        v.en = en; v.vld = vld; v.ordy = ordy;
        v.erdy = erdy; v.eovld = eovld; v.ehead = ehead; v.elvl = elvl;
        return v;
    endfunction

    function automatic logic [BW-1:0] bufv(input int i);
        return 30'h15A5_0000 + BW'(i);
    endfunction

    function automatic logic [CW-1:0] cntv(input int i);
        return CW'(i * 5);
    endfunction

    function automatic logic [DW-1:0] word(input int id, input logic [CW-1:0] c, input logic [BW-1:0] b);
        logic [1:0] idb;
        idb = id[1:0];
        return {idb, c, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic default_data();
        for (int i = 0; i < NC; i++) begin
            bq[i] = bufv(i);
            cq[i] = cntv(i);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Round-robin walk, wrap, skip-over-idle cores, and IDLE gating.
        tbl[0]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 0);
        tbl[1]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 0);
        tbl[2]  = mk(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 0, 0);
        tbl[3]  = mk(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 0, 1);
        tbl[4]  = mk(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 1, 1);
        tbl[5]  = mk(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2, 1);
        tbl[6]  = mk(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 3, 1);
        tbl[7]  = mk(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 0, 1);
        tbl[8]  = mk(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 1, 1);
        tbl[9]  = mk(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2, 1);
        tbl[10] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 3, 1);
        tbl[11] = mk(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 0, 0);
        tbl[12] = mk(1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 2, 1);
        tbl[13] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 2);
        tbl[14] = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 0, 1);
        tbl[15] = mk(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 0);

        reset = 1'b1; enable = 1'b0; test_ending = 1'b0; req_valid = '0;
        out_ready = 1'b0; clear_stall = 1'b0;
        default_data();
        #12 reset = 1'b0;
        tick();

        #1;
        chk("reset out_data", out_data, 0);
        chk("reset stall_seen", stall_seen, 0);
        chk("reset test_has_ended", test_has_ended, 0);

        for (int n = 0; n < 16; n++) begin
            enable = tbl[n].en; req_valid = tbl[n].vld; out_ready = tbl[n].ordy;
            #1;
            chk($sformatf("v%0d req_ready", n), req_ready, tbl[n].erdy);
            chk($sformatf("v%0d out_valid", n), out_valid, tbl[n].eovld);
            chk($sformatf("v%0d fifo_level", n), fifo_level, tbl[n].elvl);
            if (tbl[n].eovld)
                chk($sformatf("v%0d out_data", n), out_data,
                    word(tbl[n].ehead, cntv(tbl[n].ehead), bufv(tbl[n].ehead)));
            tick();
        end

        // Single requester with a specific frame.
        bq[2] = 30'h2AAA_AAAA; cq[2] = 4'd5;
        req_valid = 4'b0100; out_ready = 1'b0;
        #1 chk("single req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single out_valid", out_valid, 1);
        chk("single out_data", out_data, {2'd2, 4'd5, 30'h2AAA_AAAA});
        chk("single fifo_level", fifo_level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        default_data();
        #1 chk("single drained", fifo_level, 0);

        // Fill to 16 from core 1 with the sink stalled.
        accepted = 0;
        req_valid = 4'b0010;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk($sformatf("fill%0d req_ready1", i), req_ready[1], (i < 16) ? 1 : 0);
            chk($sformatf("fill%0d level", i), fifo_level, i);
            if (req_ready[1]) accepted++;
            tick();
        end
        #1;
        chk("fill accepted", accepted, 16);
        chk("fill level", fifo_level, 16);
        chk("fill stall_seen", stall_seen, 4'b0010);

        // Pop at full with a pending request and a clear racing a set.
        out_ready = 1'b1; clear_stall = 1'b1;
        #1 chk("full pop req_ready", req_ready, 0);
        tick();
        clear_stall = 1'b0; req_valid = '0;
        #1;
        chk("full pop level", fifo_level, 15);
        chk("clear_stall wins", stall_seen, 0);
        for (int i = 0; i < 7; i++) tick();
        #1 chk("level 8", fifo_level, 8);
        req_valid = 4'b0010;
        #1;
        chk("push+pop req_ready", req_ready, 4'b0010);
        chk("push+pop head", out_data, word(1, cntv(1), bufv(1)));
        tick();
        req_valid = '0;
        #1 chk("push+pop level", fifo_level, 8);
        for (int k = 0; k < 20 && out_valid; k++) tick();
        #1 chk("emptied level", fifo_level, 0);
        out_ready = 1'b0;

        // Drain: queue 3, request end of test, requests must not be granted.
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("queue%0d req_ready", k), req_ready, 4'b1000);
            tick();
        end
        req_valid = '0; test_ending = 1'b1;
        #1 chk("queued level", fifo_level, 3);
        tick();
        req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        chk("drain0 req_ready", req_ready, 0);
        chk("drain0 level", fifo_level, 3);
        tick();
        test_ending = 1'b0;
        #1;
        chk("drain1 req_ready", req_ready, 0);
        chk("drain1 level", fifo_level, 2);
        tick();
        #1;
        chk("drain2 req_ready", req_ready, 0);
        chk("drain2 level", fifo_level, 1);
        tick();
        #1;
        chk("drain3 out_valid", out_valid, 0);
        chk("drain3 ended", test_has_ended, 0);
        tick();
        #1;
        chk("done entry ended", test_has_ended, 0);
        chk("done req_ready", req_ready, 0);
        tick();
        #1 chk("done ended", test_has_ended, 1);
        enable = 1'b0;
        tick();
        #1;
        chk("idle req_ready", req_ready, 0);
        chk("idle ended lag", test_has_ended, 1);
        enable = 1'b1;
        tick();
        #1;
        chk("rerun ended", test_has_ended, 0);
        chk("rerun req_ready", req_ready, 4'b0001);
        req_valid = '0;
        out_ready = 1'b0;

        // Reset in the middle of RUN with entries queued.
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) tick();
        req_valid = '0;
        #1 chk("pre-reset level", fifo_level, 5);
        req_valid = 4'b1111;
        #1 chk("pre-reset req_ready", req_ready, 4'b1000);
        reset = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset level", fifo_level, 0);
        chk("async reset req_ready", req_ready, 0);
        chk("async reset out_data", out_data, 0);
        #2 reset = 1'b0;
        tick();
        #1;
        chk("post-reset priority", req_ready, 4'b0001);
        chk("post-reset level", fifo_level, 0);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
